// File: rtl/sdrc_app_pkg.sv
// sdrc_app_pkg: shared constants for the SDRAM application-port master.
// State codes, request direction encodings and default burst depth.
package sdrc_app_pkg;

    localparam int MAX_BURST_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WFILL = 3'd1;
    localparam state_t ST_REQ   = 3'd2;
    localparam state_t ST_WDATA = 3'd3;
    localparam state_t ST_RDATA = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

endpackage

// File: rtl/sdrc_app_wbuf.sv
// sdrc_app_wbuf: write burst staging buffer, data plus active-low mask.
// Filled by the client side, drained word by word by the controller.
module sdrc_app_wbuf
    import sdrc_app_pkg::*;
#(
    parameter int DW    = 32,
    parameter int BW    = 4,
    parameter int DEPTH = MAX_BURST_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic [BW-1:0] wr_mask,
    input  logic          rd_adv,
    output logic [DW-1:0] rd_data,
    output logic [BW-1:0] rd_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = DW + BW;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] wptr_d;
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] rptr_d;
    logic [EW-1:0] rd_ent;

    // Pointer advance and entry write; clear restarts both pointers.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_en) begin
                mem_d[wptr_q] = {wr_mask, wr_data};
                wptr_d        = wptr_q + PW'(1);
            end
            if (rd_adv) begin
                rptr_d = rptr_q + PW'(1);
            end
        end
    end

    // Pointer registers; reset discards whatever was buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: it is only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_ent  = mem_q[rptr_q];
    assign rd_data = rd_ent[DW-1:0];
    assign rd_mask = rd_ent[EW-1:DW];

endmodule

// File: rtl/sdrc_app_master.sv
// sdrc_app_master: client command/data stream to SDRAM controller app port.
// Writes are fully buffered before requesting; reads stream through.
module sdrc_app_master
    import sdrc_app_pkg::*;
#(
    parameter int APP_AW    = 26,
    parameter int APP_DW    = 32,
    parameter int APP_BW    = 4,
    parameter int BL_W      = 9,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int LEN_W     = 4
) (
    input  logic              sdram_clk,
    input  logic              sdram_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [APP_DW-1:0] wdata,
    input  logic [APP_BW-1:0] wstrb,
    output logic              rdata_valid,
    output logic [APP_DW-1:0] rdata,
    output logic              rdata_last,
    output logic              done,
    input  logic              sdr_init_done,
    output logic              app_req,
    output logic [APP_AW-1:0] app_req_addr,
    output logic [BL_W-1:0]   app_req_len,
    output logic              app_req_wr_n,
    output logic              app_req_wrap,
    input  logic              app_req_ack,
    output logic [APP_BW-1:0] app_wr_en_n,
    output logic [APP_DW-1:0] app_wr_data,
    input  logic              app_wr_next_req,
    input  logic              app_rd_valid,
    input  logic              app_last_rd,
    input  logic              app_last_wr,
    input  logic [APP_DW-1:0] app_rd_data
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

    state_t            state_q;
    state_t            state_d;
    logic [APP_AW-1:0] addr_q;
    logic [APP_AW-1:0] addr_d;
    logic              wr_q;
    logic              wr_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_d;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  cnt_d;
    logic              rvalid_q;
    logic              rvalid_d;
    logic              rlast_q;
    logic              rlast_d;
    logic [APP_DW-1:0] rdata_q;
    logic [APP_DW-1:0] rdata_d;

    logic [LEN_W-1:0]  eff_len;
    logic [LEN_W-1:0]  cnt_inc;
    logic              rd_fin;
    logic              buf_clr;
    logic              buf_wr;
    logic              buf_adv;
    logic [APP_DW-1:0] buf_data;
    logic [APP_BW-1:0] buf_mask;

    // Oversized lengths clamp to one full burst rather than wrapping.
    assign eff_len = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    assign cnt_inc = cnt_q + LEN_W'(1);
    // Final read word is on the output this cycle.
    assign rd_fin  = rvalid_q & rlast_q;

    sdrc_app_wbuf #(
        .DW    (APP_DW),
        .BW    (APP_BW),
        .DEPTH (MAX_BURST)
    ) u_wbuf (
        .clk     (sdram_clk),
        .rst     (sdram_reset),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (wdata),
        .wr_mask (~wstrb),
        .rd_adv  (buf_adv),
        .rd_data (buf_data),
        .rd_mask (buf_mask)
    );

    // Command sequencing: accept, fill, request, move data, report done.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        rvalid_d    = 1'b0;
        rlast_d     = 1'b0;
        rdata_d     = rdata_q;
        buf_clr     = 1'b0;
        buf_wr      = 1'b0;
        buf_adv     = 1'b0;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        app_req     = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = sdr_init_done;
                if (cmd_valid && sdr_init_done) begin
                    addr_d  = cmd_addr;
                    wr_d    = cmd_wr;
                    len_d   = eff_len;
                    cnt_d   = '0;
                    buf_clr = 1'b1;
                    if (eff_len == '0) begin
                        state_d = ST_DONE;
                    end else if (cmd_wr) begin
                        state_d = ST_WFILL;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_WFILL: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    buf_wr = 1'b1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == len_q) begin
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                app_req = 1'b1;
                if (app_req_ack) begin
                    state_d = wr_q ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                if (app_wr_next_req) begin
                    buf_adv = 1'b1;
                    cnt_d   = cnt_inc;
                end
                if ((app_wr_next_req && cnt_inc == len_q) || app_last_wr) begin
                    state_d = ST_DONE;
                end
            end
            ST_RDATA: begin
                if (app_rd_valid && !rd_fin) begin
                    rvalid_d = 1'b1;
                    rdata_d  = app_rd_data;
                    cnt_d    = cnt_inc;
                    rlast_d  = (cnt_inc == len_q) || app_last_rd;
                end
                if (rd_fin) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rdata_q  <= rdata_d;
        end
    end

    assign app_req_addr = addr_q;
    assign app_req_len  = BL_W'(len_q);
    assign app_req_wr_n = wr_q ? OP_WR : OP_RD;
    assign app_req_wrap = 1'b0;
    assign app_wr_data  = (state_q == ST_WDATA) ? buf_data : '0;
    assign app_wr_en_n  = (state_q == ST_WDATA) ? buf_mask : '1;
    assign rdata_valid  = rvalid_q & (state_q == ST_RDATA);
    assign rdata        = rdata_q;
    assign rdata_last   = rlast_q & rdata_valid;

endmodule

// File: tb/tb_sdrc_app_master.sv
// tb_sdrc_app_master: client + controller model around sdrc_app_master.
// Directed table, reset/gating sequences and random commands.
module tb_sdrc_app_master;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int BLW = 9;
    localparam int LW = 4;
    localparam int MB = 8;

    logic          sdram_clk = 1'b0;
    logic          sdram_reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [DW-1:0] wdata;
    logic [BW-1:0] wstrb;
    logic          rdata_valid;
    logic [DW-1:0] rdata;
    logic          rdata_last;
    logic          done;
    logic          sdr_init_done;
    logic          app_req;
    logic [AW-1:0] app_req_addr;
    logic [BLW-1:0] app_req_len;
    logic          app_req_wr_n;
    logic          app_req_wrap;
    logic          app_req_ack;
    logic [BW-1:0] app_wr_en_n;
    logic [DW-1:0] app_wr_data;
    logic          app_wr_next_req;
    logic          app_rd_valid;
    logic          app_last_rd;
    logic          app_last_wr;
    logic [DW-1:0] app_rd_data;

    int total = 0;
    int bad = 0;

    always #5 sdram_clk = ~sdram_clk;

    sdrc_app_master dut (
        .sdram_clk       (sdram_clk),
        .sdram_reset     (sdram_reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_wr          (cmd_wr),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wdata_valid     (wdata_valid),
        .wdata_ready     (wdata_ready),
        .wdata           (wdata),
        .wstrb           (wstrb),
        .rdata_valid     (rdata_valid),
        .rdata           (rdata),
        .rdata_last      (rdata_last),
        .done            (done),
        .sdr_init_done   (sdr_init_done),
        .app_req         (app_req),
        .app_req_addr    (app_req_addr),
        .app_req_len     (app_req_len),
        .app_req_wr_n    (app_req_wr_n),
        .app_req_wrap    (app_req_wrap),
        .app_req_ack     (app_req_ack),
        .app_wr_en_n     (app_wr_en_n),
        .app_wr_data     (app_wr_data),
        .app_wr_next_req (app_wr_next_req),
        .app_rd_valid    (app_rd_valid),
        .app_last_rd     (app_last_rd),
        .app_last_wr     (app_last_wr),
        .app_rd_data     (app_rd_data)
    );

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            ack_dly;
        logic [BW-1:0] strb;
        logic [DW-1:0] base;
        int            gap;
        int            exp_len;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid       = 1'b0;
        wdata_valid     = 1'b0;
        wdata           = '0;
        wstrb           = '0;
        app_req_ack     = 1'b0;
        app_wr_next_req = 1'b0;
        app_last_wr     = 1'b0;
        app_rd_valid    = 1'b0;
        app_last_rd     = 1'b0;
        app_rd_data     = '0;
    endtask

    // One command end to end; the bench plays client and controller.
    // eff is the model's effective burst length for this command.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr,
                           input logic [LW-1:0] len, input int eff,
                           input int ack_dly, input logic [BW-1:0] strb,
                           input bit rnd_strb, input logic [DW-1:0] base,
                           input int gap, input int abort_at);
        logic [DW-1:0] cd[$];
        logic [BW-1:0] cs[$];
        logic [BW-1:0] em[$];
        logic [DW-1:0] gd[$];
        logic [BW-1:0] gm[$];
        logic [DW-1:0] rq[$];
        bit            rl[$];
        logic [BW-1:0] s;
        int ci = 0, ws = 0, rs = 0, reqc = 0, dn = 0, cyc = 0;
        int acc_c = -1, done_c = -1, last_c = -1;
        bit acc = 0, ack = 0, prv = 0, fin = 0, stop = 0;

        for (int i = 0; i < eff; i++) begin
            s = rnd_strb ? BW'($urandom) : strb;
            cd.push_back(base + DW'(i));
            cs.push_back(s);
            em.push_back(~s);
        end
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_len   = len;

        while (!fin) begin
            @(negedge sdram_clk);
            cyc++;
            chk("rdata_valid_latency", rdata_valid, prv);
            prv = app_rd_valid;
            if (cmd_valid && cmd_ready) begin
                acc   = 1;
                acc_c = cyc;
            end
            if (wdata_valid && wdata_ready) ci++;
            if (app_req) begin
                reqc++;
                chk("req_addr", app_req_addr, addr);
                chk("req_len", app_req_len, eff);
                chk("req_wr_n", app_req_wr_n, !wr);
                if (app_req_ack) ack = 1;
            end
            if (app_wr_next_req) begin
                gd.push_back(app_wr_data);
                gm.push_back(app_wr_en_n);
                ws++;
                last_c = cyc;
            end
            if (app_rd_valid) rs++;
            if (rdata_valid) begin
                rq.push_back(rdata);
                rl.push_back(rdata_last);
                last_c = cyc;
            end
            if (done) begin
                dn++;
                done_c = cyc;
                fin    = 1;
            end
            if (cyc > 300) begin
                total++;
                bad++;
                $display("FAIL timeout wr=%0d len=%0d cycles=%0d", wr, len, cyc);
                fin  = 1;
                stop = 1;
            end
            if (abort_at >= 0 && ws == abort_at) begin
                fin  = 1;
                stop = 1;
            end
            @(posedge sdram_clk);
            #1;
            cmd_valid   = !acc;
            wdata_valid = wr && acc && ci < eff && $urandom_range(99) >= gap;
            if (ci < eff) begin
                wdata = cd[ci];
                wstrb = cs[ci];
            end
            app_req_ack = app_req && !ack && reqc == ack_dly;
            app_wr_next_req = wr && ack && ws < eff && $urandom_range(99) >= gap;
            app_last_wr = app_wr_next_req && ws == eff - 1;
            app_rd_valid = !wr && ack && rs < eff && $urandom_range(99) >= gap;
            app_rd_data = app_rd_valid ? base + DW'(rs) : DW'($urandom);
            app_last_rd = app_rd_valid && rs == eff - 1;
        end
        idle_inputs();

        if (stop) begin
            sdram_reset = 1'b1;
            @(posedge sdram_clk);
            #1;
            sdram_reset = 1'b0;
            chk("abort_app_req", app_req, 1'b0);
            chk("abort_en_n", app_wr_en_n, 4'hF);
            chk("abort_idle_ready", cmd_ready, 1'b1);
            chk("abort_wdata_ready", wdata_ready, 1'b0);
            chk("abort_done", done, 1'b0);
            return;
        end

        chk("done_count", dn, 1);
        chk("en_n_after", app_wr_en_n, 4'hF);
        chk("wrap", app_req_wrap, 1'b0);
        if (eff == 0) begin
            chk("no_req", reqc, 0);
            chk("done_time", done_c, acc_c + 1);
        end else begin
            chk("req_cycles", reqc, ack_dly + 1);
            chk("done_time", done_c, last_c + 1);
        end
        if (wr) begin
            chk("wr_words", gd.size(), eff);
            for (int i = 0; i < eff && i < gd.size(); i++) begin
                chk("wr_data", gd[i], cd[i]);
                chk("wr_en_n", gm[i], em[i]);
            end
        end else begin
            chk("rd_words", rq.size(), eff);
            for (int i = 0; i < eff && i < rq.size(); i++) begin
                chk("rd_data", rq[i], base + DW'(i));
                chk("rd_last", rl[i], i == eff - 1);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge sdram_clk);
            chk("done_single", done, 1'b0);
        end
        @(posedge sdram_clk);
        #1;
    endtask

    vec_t          tbl[8];
    bit            r_wr;
    logic [LW-1:0] r_len;
    int            r_eff;

    initial begin
        tbl[0] = '{1'b1, 26'h100,     4'd4,  2, 4'hF,    32'hA0, 0,  4};
        tbl[1] = '{1'b0, 26'h2000,    4'd8,  1, 4'hF,    32'h10, 40, 8};
        tbl[2] = '{1'b1, 26'h0ABC,    4'd1,  0, 4'b0101, 32'h55, 0,  1};
        tbl[3] = '{1'b0, 26'h3FFFFFF, 4'd0,  0, 4'hF,    32'h0,  0,  0};
        tbl[4] = '{1'b1, 26'h40,      4'd15, 0, 4'b0011, 32'h70, 20, 8};
        tbl[5] = '{1'b0, 26'h77,      4'd9,  3, 4'hF,    32'h90, 30, 8};
        tbl[6] = '{1'b1, 26'h10,      4'd0,  0, 4'hF,    32'h0,  0,  0};
        tbl[7] = '{1'b0, 26'h5,       4'd1,  0, 4'hF,    32'hE0, 0,  1};

        idle_inputs();
        cmd_wr        = 1'b0;
        cmd_addr      = '0;
        cmd_len       = '0;
        sdr_init_done = 1'b0;
        sdram_reset   = 1'b1;
        repeat (3) @(posedge sdram_clk);
        #1;
        sdram_reset = 1'b0;

        @(negedge sdram_clk);
        chk("rst_app_req", app_req, 1'b0);
        chk("rst_wr_n", app_req_wr_n, 1'b1);
        chk("rst_en_n", app_wr_en_n, 4'hF);
        chk("rst_req_len", app_req_len, 0);
        chk("rst_req_addr", app_req_addr, 0);
        chk("rst_wr_data", app_wr_data, 0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdata_valid", rdata_valid, 1'b0);
        chk("rst_wdata_ready", wdata_ready, 1'b0);

        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 26'h123;
        cmd_len   = 4'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge sdram_clk);
            chk("gate_ready", cmd_ready, 1'b0);
            chk("gate_req", app_req, 1'b0);
        end
        @(posedge sdram_clk);
        #1;
        sdr_init_done = 1'b1;
        @(negedge sdram_clk);
        chk("gate_ready_on", cmd_ready, 1'b1);
        cmd_valid = 1'b0;
        @(posedge sdram_clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].exp_len,
                    tbl[i].ack_dly, tbl[i].strb, 1'b0, tbl[i].base,
                    tbl[i].gap, -1);
        end

        run_txn(1'b1, 26'h300, 4'd4, 4, 0, 4'hF, 1'b0, 32'hC0, 0, 2);
        run_txn(1'b0, 26'h400, 4'd3, 3, 1, 4'hF, 1'b0, 32'hD0, 0, -1);

        for (int k = 0; k < 40; k++) begin
            r_wr  = 1'($urandom_range(1));
            r_len = LW'($urandom_range(15));
            r_eff = (int'(r_len) > MB) ? MB : int'(r_len);
            run_txn(r_wr, AW'($urandom), r_len, r_eff,
                    int'($urandom_range(3)), 4'hF, 1'b1, $urandom,
                    int'($urandom_range(50)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdrc_app_master.md
Name: sdrc_app_master

Overview:
- Initiator for the SDRAM controller application request port: drives app_req/addr/len/wr_n and supplies or collects burst data.
- Sits between a simple client-side command/data stream (CPU line-fill / writeback engine, DMA) and the controller top.
- Buffers a full write burst before requesting, because the controller pulls write data without backpressure.
- Streams read data straight through, because the controller pushes read data without backpressure.

Parameters:
- APP_AW, 26, application word address width
- APP_DW, 32, application data width
- APP_BW, 4, byte lanes (APP_DW/8)
- BL_W, 9, app_req_len width
- MAX_BURST, 8, words per burst and write buffer depth (power of 2, ≤ 256)
- LEN_W, 4, cmd_len width (clog2(MAX_BURST)+1)

Ports:
- sdram_clk  in  1  clock
- sdram_reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  client command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  APP_AW  word address
- cmd_len  in  LEN_W  burst length in words
- wdata_valid  in  1  write word valid
- wdata_ready  out  1  write word accepted
- wdata  in  APP_DW  write data
- wstrb  in  APP_BW  byte enables, active high
- rdata_valid  out  1  read word valid (no backpressure)
- rdata  out  APP_DW  read data
- rdata_last  out  1  final read word of burst
- done  out  1  one-cycle pulse when a command completes
- sdr_init_done  in  1  controller initialisation complete
- app_req  out  1  request to controller
- app_req_addr  out  APP_AW  request address
- app_req_len  out  BL_W  request length
- app_req_wr_n  out  1  0 = write, 1 = read
- app_req_wrap  out  1  tied 0
- app_req_ack  in  1  request accepted
- app_wr_en_n  out  APP_BW  byte write enable, active low
- app_wr_data  out  APP_DW  write data
- app_wr_next_req  in  1  controller consumed the current write word
- app_rd_valid  in  1  read word valid
- app_last_rd  in  1  last read word
- app_last_wr  in  1  last write word
- app_rd_data  in  APP_DW  read data

Behaviour:
- Reset: all outputs 0 except app_req_wr_n=1 and app_wr_en_n=all 1s. FSM→IDLE; pointers and counters cleared.
- Reset mid-operation: app_req drops the cycle after reset is sampled. Buffered data is discarded. The client must reissue.
- FSM states: IDLE, WFILL, REQ, WDATA, RDATA, DONE.
- IDLE:
  - cmd_ready = sdr_init_done.
  - On accept, latch addr, wr, and eff_len.
  - eff_len = min(cmd_len, MAX_BURST).
  - eff_len = 0: go to DONE; no SDRAM traffic.
  - Otherwise: wr → WFILL, read → REQ.
- WFILL:
  - wdata_ready=1.
  - Each accepted word is stored with ~wstrb in buf[wptr]; wptr++.
  - After eff_len words → REQ.
  - wdata_ready=0 in every other state.
- REQ:
  - app_req=1; app_req_addr/len/wr_n held stable until the cycle app_req_ack=1.
  - app_req_len = eff_len zero-extended.
  - On ack: app_req drops next cycle; wr → WDATA, read → RDATA.
  - Ack may arrive in the first REQ cycle.
- WDATA:
  - app_wr_data = buf[rptr] and app_wr_en_n = stored mask, combinational from rptr.
  - rptr++ on each app_wr_next_req.
  - When the count reaches eff_len, or app_last_wr=1 → DONE.
  - Outside WDATA, app_wr_en_n = all 1s.
- RDATA:
  - rdata_valid/rdata registered from app_rd_valid/app_rd_data (1-cycle latency).
  - rdata_last asserted with the eff_len-th word.
  - On that word, or app_last_rd → DONE.
  - rdata_valid is gated to 0 outside RDATA.
- DONE: done=1 for one cycle → IDLE. Next cmd accepted earliest the cycle after DONE.
- Widths: word counters are LEN_W bits. cmd_len > MAX_BURST is clamped, never wrapped. Address is passed unmodified; the controller splits row crossings.
- sdr_init_done deasserting outside IDLE does not abort the current command.

Decomposition:
- Shared package sdrc_app_pkg: FSM state enum, OP_WR/OP_RD encodings for app_req_wr_n, default MAX_BURST.
- One sub-module, sdrc_app_wbuf: MAX_BURST×(APP_DW+APP_BW) register buffer with write pointer, read pointer and clear.

Test Plan:
- Init gating: sdr_init_done=0 with cmd_valid=1 → cmd_ready=0, no app_req; init_done=1 → accepted next cycle.
- Write, 4 words: addr 0x100, data 0xA0..0xA3, wstrb=4'hF, ack delayed 3 cycles → app_req held 3 cycles, then app_req_len=4 and app_req_wr_n=0. app_wr_data sequence is 0xA0..0xA3, advancing only on app_wr_next_req. One done pulse.
- Read, 8 words: addr 0x2000, controller returns 0x10..0x17 with gaps → rdata mirrors the sequence one cycle late, rdata_last on 0x17, done the following cycle.
- Partial strobes: wstrb 4'b0101 → app_wr_en_n=4'b1010 for that word.
- Boundaries: cmd_len=0 → done next cycle, app_req never asserted. cmd_len=15 → app_req_len=8.
- Reset mid-burst: assert sdram_reset during WDATA after 2 words → app_req=0, FSM in IDLE, app_wr_en_n=4'hF next cycle. A new read then completes normally.
